uart_rx_fifo_controller: RTL and testbench

Parametrised UART receiver. Adds configurable data width, runtime parity and stop-bit modes, 3-sample majority voting, start-bit glitch rejection, break detection and a first-word-fall-through RX FIFO. It sits between the UART RX pin and the AXI-Lite register front end. It consumes the shared oversampling `baud_tick` from the baud generator.

---
 rtl/uart_rx_fifo_controller.sv | 193 +++++++++++++++++++
 tb/tb_uart_rx_fifo_controller.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_controller.sv
// UART receiver: 2-flop input synchroniser, 3-sample majority voting, runtime
// parity / stop-bit modes, break detection and a first-word-fall-through RX FIFO.
module uart_rx_fifo_controller #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          Clk,
  input  logic                          Resetn,
  input  logic                          Enable,
  input  logic                          baud_tick,
  input  logic                          UART_RX_I,
  input  logic [1:0]                    Parity_mode,
  input  logic                          Two_stop,
  input  logic                          Unload_data,
  input  logic                          Clear_status,
  output logic [DATA_BITS-1:0]          RX_data,
  output logic                          Empty,
  output logic                          Full,
  output logic [$clog2(FIFO_DEPTH):0]   Count,
  output logic                          Overrun,
  output logic                          Frame_error,
  output logic                          Parity_error,
  output logic                          Break_detect
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int M  = OVERSAMPLE / 2;
  localparam logic [TW-1:0] T_S0   = TW'(M - 1);
  localparam logic [TW-1:0] T_S1   = TW'(M);
  localparam logic [TW-1:0] T_VOTE = TW'(M + 1);
  localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state_reg, state_next;

  logic                 rx_meta, rx_s;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [1:0]           samp_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_en_reg, par_odd_reg, two_stop_reg;
  logic                 par_err_reg, par_bit_reg, stop_bad_reg;
  logic                 tick_vote, tick_end, vote, start_det, frame_done;
  logic                 stop_bad_all, is_break, push_req, do_push, do_pop;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count_reg;

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= UART_RX_I;
      rx_s    <= rx_meta;
    end
  end

  // The third sample is the live synchronised line at the vote tick.
  assign tick_vote = baud_tick && (tick_cnt == T_VOTE);
  assign tick_end  = baud_tick && (tick_cnt == T_END);
  assign vote      = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & rx_s) | (samp_reg[1] & rx_s);
  assign start_det = (state_reg == IDLE) && Enable && !rx_s;

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    frame_done = 1'b0;
    case (state_reg)
      IDLE:   if (start_det) state_next = START;
      START: begin
        if (tick_vote && vote) state_next = IDLE;
        else if (tick_end)     state_next = DATA;
      end
      DATA:   if (tick_end && bit_cnt == B_LAST) state_next = par_en_reg ? PARITY : STOP;
      PARITY: if (tick_end) state_next = STOP;
      STOP: begin
        if (tick_vote && (!two_stop_reg || bit_cnt != '0)) begin
          frame_done = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (state_reg != IDLE && !Enable) begin
      state_next = IDLE;
      frame_done = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      samp_reg     <= 2'b11;
      shift_reg    <= '0;
      par_en_reg   <= 1'b0;
      par_odd_reg  <= 1'b0;
      two_stop_reg <= 1'b0;
      par_err_reg  <= 1'b0;
      par_bit_reg  <= 1'b0;
      stop_bad_reg <= 1'b0;
    end else if (state_reg == IDLE) begin
      if (start_det) begin
        tick_cnt     <= '0;
        bit_cnt      <= '0;
        par_en_reg   <= ^Parity_mode;
        par_odd_reg  <= Parity_mode[1];
        two_stop_reg <= Two_stop;
        par_err_reg  <= 1'b0;
        par_bit_reg  <= 1'b0;
        stop_bad_reg <= 1'b0;
      end
    end else if (baud_tick) begin
      tick_cnt <= tick_end ? '0 : tick_cnt + 1'b1;
      if (tick_cnt == T_S0) samp_reg[0] <= rx_s;
      if (tick_cnt == T_S1) samp_reg[1] <= rx_s;
      if (tick_vote) begin
        case (state_reg)
          DATA:   shift_reg <= {vote, shift_reg[DATA_BITS-1:1]};
          PARITY: begin
            par_bit_reg <= vote;
            par_err_reg <= (^shift_reg) ^ vote ^ par_odd_reg;
          end
          STOP:   stop_bad_reg <= stop_bad_reg | ~vote;
          default: ;
        endcase
      end
      if (tick_end) begin
        case (state_reg)
          DATA:    bit_cnt <= (bit_cnt == B_LAST) ? '0 : bit_cnt + 1'b1;
          STOP:    bit_cnt <= BW'(1);
          default: ;
        endcase
      end
    end
  end

  // Frame outcome is resolved on the final stop vote, using that vote directly.
  assign stop_bad_all = stop_bad_reg | ~vote;
  assign is_break     = (shift_reg == '0) && !(par_en_reg && par_bit_reg);
  assign push_req     = frame_done && !stop_bad_all;
  assign do_pop       = Unload_data && (count_reg != '0);
  assign do_push      = push_req && ((count_reg != C_FULL) || do_pop);

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_reg <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
      else if (!do_push && do_pop) count_reg <= count_reg - 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (do_push) mem[wr_ptr] <= shift_reg;
  end

  assign RX_data = (count_reg == '0) ? '0 : mem[rd_ptr];
  assign Empty   = (count_reg == '0);
  assign Full    = (count_reg == C_FULL);
  assign Count   = count_reg;

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      Overrun      <= 1'b0;
      Frame_error  <= 1'b0;
      Parity_error <= 1'b0;
      Break_detect <= 1'b0;
    end else begin
      Overrun      <= (push_req && !do_push) | (Overrun & ~Clear_status);
      Frame_error  <= (frame_done && stop_bad_all) | (Frame_error & ~Clear_status);
      Parity_error <= (push_req && par_err_reg) | (Parity_error & ~Clear_status);
      Break_detect <= (frame_done && stop_bad_all && is_break) | (Break_detect & ~Clear_status);
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo_controller.sv
// Self-checking bench for uart_rx_fifo_controller: table-driven frames plus
// hand-written timing, glitch, overrun and reset sequences; FIFO data via scoreboard.
module tb_uart_rx_fifo_controller;
  localparam int DW = 8;
  localparam int OS = 16;
  localparam int FD = 4;

  logic          Clk = 1'b0;
  logic          Resetn = 1'b0;
  logic          Enable = 1'b0;
  logic          baud_tick = 1'b0;
  logic          UART_RX_I = 1'b1;
  logic [1:0]    Parity_mode = 2'b00;
  logic          Two_stop = 1'b0;
  logic          Unload_data = 1'b0;
  logic          Clear_status = 1'b0;
  logic [DW-1:0] RX_data;
  logic          Empty, Full;
  logic [2:0]    Count;
  logic          Overrun, Frame_error, Parity_error, Break_detect;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  int         model_count = 0;

  typedef struct {
    logic [7:0] data;
    logic [1:0] pmode;
    logic       two_stop;
    logic       bad_par;
    logic       stop1;
    logic       stop2;
    logic       exp_push;
    logic       exp_perr;
    logic       exp_ferr;
    logic       exp_brk;
  } vec_t;

  uart_rx_fifo_controller #(.DATA_BITS(DW), .OVERSAMPLE(OS), .FIFO_DEPTH(FD)) dut (
    .Clk(Clk), .Resetn(Resetn), .Enable(Enable), .baud_tick(baud_tick),
    .UART_RX_I(UART_RX_I), .Parity_mode(Parity_mode), .Two_stop(Two_stop),
    .Unload_data(Unload_data), .Clear_status(Clear_status), .RX_data(RX_data),
    .Empty(Empty), .Full(Full), .Count(Count), .Overrun(Overrun),
    .Frame_error(Frame_error), .Parity_error(Parity_error), .Break_detect(Break_detect)
  );

  always #5 Clk = ~Clk;

  // One baud_tick every 4 clocks, changed on the falling edge.
  initial begin : tick_gen
    int div;
    div = 0;
    forever begin
      @(negedge Clk);
      div = (div + 1) % 4;
      baud_tick = (div == 0);
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      while (baud_tick !== 1'b1) @(posedge Clk);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge Clk);
    UART_RX_I = b;
    wait_ticks(OS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input logic ts,
                            input logic bad_par, input logic s1, input logic s2);
    Parity_mode = pm;
    Two_stop    = ts;
    wait_ticks(1);
    send_bit(1'b0);
    for (int i = 0; i < DW; i++) send_bit(d[i]);
    if (^pm) send_bit((^d) ^ pm[1] ^ bad_par);
    send_bit(s1);
    if (ts) send_bit(s2);
    @(negedge Clk);
    UART_RX_I = 1'b1;
  endtask

  task automatic expect_push(input logic [7:0] d);
    if (model_count < FD) begin
      exp_q.push_back(d);
      model_count++;
    end
  endtask

  task automatic unload(input string name);
    logic [7:0] e;
    @(negedge Clk);
    e = exp_q.pop_front();
    check({name, "_data"}, {24'h0, RX_data}, {24'h0, e});
    Unload_data = 1'b1;
    @(negedge Clk);
    Unload_data = 1'b0;
    model_count--;
  endtask

  task automatic check_flags(input string tag, input logic o, input logic f,
                             input logic p, input logic b);
    @(negedge Clk);
    check({tag, "_overrun"}, {31'h0, Overrun}, {31'h0, o});
    check({tag, "_frame"},   {31'h0, Frame_error}, {31'h0, f});
    check({tag, "_parity"},  {31'h0, Parity_error}, {31'h0, p});
    check({tag, "_break"},   {31'h0, Break_detect}, {31'h0, b});
  endtask

  task automatic clear_flags();
    @(negedge Clk);
    Clear_status = 1'b1;
    @(negedge Clk);
    Clear_status = 1'b0;
  endtask

  initial begin : main
    vec_t       vt[10];
    logic [7:0] d1;
    string      tag;

    vt[0] = '{8'hA5, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[1] = '{8'h07, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[2] = '{8'h55, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[3] = '{8'h3C, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[4] = '{8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[5] = '{8'hC3, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[6] = '{8'h81, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[7] = '{8'h00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[8] = '{8'hFF, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[9] = '{8'h12, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(negedge Clk);
    check("rst_empty", {31'h0, Empty}, 32'h1);
    check("rst_full",  {31'h0, Full}, 32'h0);
    check("rst_count", {29'h0, Count}, 32'h0);
    check("rst_data",  {24'h0, RX_data}, 32'h0);
    check_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    Resetn = 1'b1;
    Enable = 1'b1;
    wait_ticks(4);

    // 8N1 0xA5: word must appear exactly one clock after vote tick 9 of the stop bit
    d1 = 8'hA5;
    Parity_mode = 2'b00;
    Two_stop    = 1'b0;
    wait_ticks(1);
    send_bit(1'b0);
    for (int i = 0; i < DW; i++) send_bit(d1[i]);
    @(negedge Clk);
    UART_RX_I = 1'b1;
    wait_ticks(9);
    @(negedge Clk);
    check("t1_empty_before_vote", {31'h0, Empty}, 32'h1);
    wait_ticks(1);
    @(negedge Clk);
    check("t1_empty_after_vote", {31'h0, Empty}, 32'h0);
    check("t1_count", {29'h0, Count}, 32'h1);
    expect_push(d1);
    wait_ticks(24);
    check_flags("t1", 1'b0, 1'b0, 1'b0, 1'b0);
    unload("t1");

    // Table of frames
    for (int v = 0; v < 10; v++) begin
      tag = $sformatf("vec%0d", v);
      clear_flags();
      send_frame(vt[v].data, vt[v].pmode, vt[v].two_stop, vt[v].bad_par, vt[v].stop1, vt[v].stop2);
      if (vt[v].exp_push) expect_push(vt[v].data);
      wait_ticks(2 * OS);
      check_flags(tag, 1'b0, vt[v].exp_ferr, vt[v].exp_perr, vt[v].exp_brk);
      check({tag, "_count"}, {29'h0, Count}, model_count);
      if (vt[v].exp_push) unload(tag);
    end
    clear_flags();
    check_flags("cleared", 1'b0, 1'b0, 1'b0, 1'b0);

    // Start-bit glitch of 3 ticks, then a valid frame
    wait_ticks(1);
    @(negedge Clk);
    UART_RX_I = 1'b0;
    wait_ticks(3);
    @(negedge Clk);
    UART_RX_I = 1'b1;
    wait_ticks(2 * OS);
    @(negedge Clk);
    check("glitch_empty", {31'h0, Empty}, 32'h1);
    check_flags("glitch", 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h3C, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    expect_push(8'h3C);
    wait_ticks(2 * OS);
    unload("after_glitch");

    // Overrun: five frames into a four-deep FIFO
    for (int k = 1; k <= 5; k++) begin
      send_frame(8'(k), 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
      expect_push(8'(k));
      wait_ticks(OS);
    end
    @(negedge Clk);
    check("ovr_count", {29'h0, Count}, model_count);
    check("ovr_full", {31'h0, Full}, 32'h1);
    check_flags("ovr", 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) unload($sformatf("ovr_pop%0d", k));
    @(negedge Clk);
    check("ovr_drained_empty", {31'h0, Empty}, 32'h1);
    check("ovr_drained_count", {29'h0, Count}, 32'h0);
    clear_flags();

    // Asynchronous reset in the middle of a frame
    send_frame(8'h3C, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_ticks(OS);
    send_frame(8'h5A, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_ticks(OS);
    @(negedge Clk);
    check("pre_rst_count", {29'h0, Count}, 32'h1);
    check("pre_rst_frame", {31'h0, Frame_error}, 32'h1);
    wait_ticks(1);
    @(negedge Clk);
    UART_RX_I = 1'b0;
    wait_ticks(3 * OS);
    #2;
    Resetn = 1'b0;
    #1;
    check("midrst_empty", {31'h0, Empty}, 32'h1);
    check("midrst_count", {29'h0, Count}, 32'h0);
    check("midrst_data",  {24'h0, RX_data}, 32'h0);
    check("midrst_frame", {31'h0, Frame_error}, 32'h0);
    exp_q.delete();
    model_count = 0;
    UART_RX_I = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    Resetn = 1'b1;
    wait_ticks(4);
    send_frame(8'h96, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1);
    expect_push(8'h96);
    wait_ticks(2 * OS);
    check_flags("post_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    unload("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
